pc_gen: RTL and testbench

- Parametrised fetch-PC generator that supersedes the combinational next-PC logic.
- Holds the architectural fetch PC register and predicts the next PC with a direct-mapped branch target buffer (BTB) plus 2-bit counters.
- Resolves branches and jumps from EX using the shared BRANCH_* encodings, and redirects or flushes on mispredict, misaligned target or trap.
- Sits between IF and EX of the pipelined core.

---
 rtl/pc_gen_pkg.sv | 33 +++
 rtl/pc_gen_if.sv | 37 +++
 rtl/pc_gen_btb.sv | 79 +++++++
 rtl/pc_gen.sv | 111 +++++++++++
 tb/tb_pc_gen.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared branch encodings and BTB entry field definitions.
//   BRANCH_* : 4-bit branch/jump code carried with an instruction to EX.
//   btb_ctr_t: 2-bit saturating direction counter stored in each BTB entry.
//   ctr_update(): next counter value after a resolved branch.
package pc_gen_pkg;

   localparam logic [3:0] BRANCH_PCPLUS4 = 4'd0;
   localparam logic [3:0] BRANCH_BEQ     = 4'd1;
   localparam logic [3:0] BRANCH_BNE     = 4'd2;
   localparam logic [3:0] BRANCH_BLT     = 4'd3;
   localparam logic [3:0] BRANCH_BGE     = 4'd4;
   localparam logic [3:0] BRANCH_BLTU    = 4'd5;
   localparam logic [3:0] BRANCH_BGEU    = 4'd6;
   localparam logic [3:0] BRANCH_JAL     = 4'd7;
   localparam logic [3:0] BRANCH_JALR    = 4'd8;

   localparam int CTR_W = 2;
   typedef logic [CTR_W-1:0] btb_ctr_t;

   // A freshly allocated entry starts weakly taken.
   localparam btb_ctr_t CTR_INIT = 2'b10;

   function automatic btb_ctr_t ctr_update(btb_ctr_t c, logic taken);
      btb_ctr_t r;
      r = c;
      if (taken && c != 2'b11)
         r = c + 2'b01;
      else if (!taken && c != 2'b00)
         r = c - 2'b01;
      return r;
   endfunction

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch/resolve bus of the PC generator.
//   stall_i, ex_*, trap_*       : driven by the pipeline (master) into pc_gen.
//   pc_o, pred_*, flush_o,
//   misalign_o                  : driven by pc_gen (slave) back to IF/ID.
interface pc_gen_if #(
   parameter int XLEN = 32
);
   logic            stall_i;
   logic            ex_valid;
   logic [XLEN-1:0] ex_pc;
   logic [3:0]      ex_branch;
   logic            ex_zero;
   logic            ex_lt;
   logic [XLEN-1:0] ex_rs1;
   logic [XLEN-1:0] ex_imm;
   logic            ex_pred_taken;
   logic [XLEN-1:0] ex_pred_target;
   logic            trap_valid;
   logic [XLEN-1:0] trap_vec;
   logic [XLEN-1:0] pc_o;
   logic            pred_taken_o;
   logic [XLEN-1:0] pred_target_o;
   logic            flush_o;
   logic            misalign_o;

   modport master (
      output stall_i, ex_valid, ex_pc, ex_branch, ex_zero, ex_lt, ex_rs1, ex_imm,
             ex_pred_taken, ex_pred_target, trap_valid, trap_vec,
      input  pc_o, pred_taken_o, pred_target_o, flush_o, misalign_o
   );

   modport slave (
      input  stall_i, ex_valid, ex_pc, ex_branch, ex_zero, ex_lt, ex_rs1, ex_imm,
             ex_pred_taken, ex_pred_target, trap_valid, trap_vec,
      output pc_o, pred_taken_o, pred_target_o, flush_o, misalign_o
   );
endinterface

// File: rtl/pc_gen_btb.sv
// pc_gen_btb: direct-mapped branch target buffer with 2-bit counters.
//   clk, rstn     : clock, async active-low reset (clears valid bits only)
//   lk_pc         : fetch PC to look up (combinational)
//   lk_taken      : predicted taken for lk_pc
//   lk_target     : predicted next PC (stored target, or lk_pc+4)
//   upd_en        : write an update at the edge for upd_pc
//   upd_pc/taken/target/jump : resolved branch information from EX
module pc_gen_btb
   import pc_gen_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int BTB_DEPTH = 16
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [XLEN-1:0] lk_pc,
   output logic            lk_taken,
   output logic [XLEN-1:0] lk_target,
   input  logic            upd_en,
   input  logic [XLEN-1:0] upd_pc,
   input  logic            upd_taken,
   input  logic [XLEN-1:0] upd_target,
   input  logic            upd_jump
);
   localparam int IDX_W = $clog2(BTB_DEPTH);
   localparam int TAG_W = XLEN - IDX_W - 2;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [XLEN-1:0]  target;
      logic             is_jump;
      btb_ctr_t         ctr;
   } entry_t;

   logic [BTB_DEPTH-1:0] valid;
   entry_t               mem [BTB_DEPTH];

   logic [IDX_W-1:0] li, ui;
   logic [TAG_W-1:0] lt, ut;
   logic             lk_hit, upd_hit;
   logic [1:0]       unused_upd_lsb;

   assign li = lk_pc[IDX_W+1:2];
   assign lt = lk_pc[XLEN-1:IDX_W+2];
   assign ui = upd_pc[IDX_W+1:2];
   assign ut = upd_pc[XLEN-1:IDX_W+2];
   assign unused_upd_lsb = upd_pc[1:0];

   // Reads see pre-edge contents; a same-cycle write to the looked-up
   // index is not bypassed.
   assign lk_hit    = valid[li] && (mem[li].tag == lt);
   assign lk_taken  = lk_hit && (mem[li].is_jump || mem[li].ctr[1]);
   assign lk_target = lk_taken ? mem[li].target : lk_pc + XLEN'(4);

   assign upd_hit   = valid[ui] && (mem[ui].tag == ut);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         valid <= '0;
      else if (upd_en && !upd_hit && upd_taken)
         valid[ui] <= 1'b1;
   end

   // Entry payload needs no reset: it is ignored until its valid bit is set.
   always_ff @(posedge clk) begin
      if (upd_en) begin
         if (upd_hit) begin
            mem[ui].ctr <= ctr_update(mem[ui].ctr, upd_taken);
            if (upd_taken)
               mem[ui].target <= upd_target;
         end else if (upd_taken) begin
            mem[ui].tag     <= ut;
            mem[ui].target  <= upd_target;
            mem[ui].is_jump <= upd_jump;
            mem[ui].ctr     <= CTR_INIT;
         end
      end
   end
endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-PC register, branch resolution and next-PC selection.
//   clk, rstn : core clock, async active-low reset (pc_o <= RESET_PC)
//   bus       : pc_gen_if.slave; EX resolution inputs, trap redirect, stall,
//               and the fetch PC / prediction / flush / misalign outputs.
// Next-PC priority: trap, misaligned target, mispredict, stall, prediction,
// sequential. Redirects win over stall; flush_o is combinational.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_PC  = '0,
   parameter int              BTB_DEPTH = 16,
   parameter bit              BTB_EN    = 1'b1
) (
   input logic     clk,
   input logic     rstn,
   pc_gen_if.slave bus
);
   logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
   logic [XLEN-1:0] jalr_sum, target, actual_next;
   logic [XLEN-1:0] pred_target;
   logic            taken, is_jalr, is_jump;
   logic            misalign, mispredict, flush;
   logic            pred_taken, upd_en;

   assign pc_plus4 = pc_q + XLEN'(4);

   // taken is already qualified by ex_valid, so everything derived from it
   // is quiet when EX is empty.
   always_comb begin
      taken = 1'b0;
      if (bus.ex_valid) begin
         case (bus.ex_branch)
            BRANCH_BEQ:  taken = bus.ex_zero;
            BRANCH_BNE:  taken = ~bus.ex_zero;
            BRANCH_BLT,
            BRANCH_BLTU: taken = bus.ex_lt;
            BRANCH_BGE,
            BRANCH_BGEU: taken = ~bus.ex_lt;
            BRANCH_JAL,
            BRANCH_JALR: taken = 1'b1;
            default:     taken = 1'b0;
         endcase
      end
   end

   assign is_jalr     = (bus.ex_branch == BRANCH_JALR);
   assign is_jump     = (bus.ex_branch == BRANCH_JAL) || is_jalr;
   assign jalr_sum    = bus.ex_rs1 + bus.ex_imm;
   assign target      = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : bus.ex_pc + bus.ex_imm;
   assign actual_next = taken ? target : bus.ex_pc + XLEN'(4);

   assign misalign   = taken & target[1];
   assign mispredict = bus.ex_valid &
                       ((taken != bus.ex_pred_taken) |
                        (taken & (target != bus.ex_pred_target)));
   assign flush      = bus.trap_valid | misalign | mispredict;

   // Misaligned targets never train the predictor.
   assign upd_en = bus.ex_valid & (bus.ex_branch != BRANCH_PCPLUS4) & ~misalign;

   always_comb begin
      pc_d = pc_plus4;
      if (bus.trap_valid || misalign)
         pc_d = bus.trap_vec;
      else if (mispredict)
         pc_d = actual_next;
      else if (bus.stall_i)
         pc_d = pc_q;
      else if (pred_taken)
         pc_d = pred_target;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         pc_q <= RESET_PC;
      else
         pc_q <= pc_d;
   end

   generate
      if (BTB_EN) begin : g_btb
         pc_gen_btb #(
            .XLEN      (XLEN),
            .BTB_DEPTH (BTB_DEPTH)
         ) u_btb (
            .clk        (clk),
            .rstn       (rstn),
            .lk_pc      (pc_q),
            .lk_taken   (pred_taken),
            .lk_target  (pred_target),
            .upd_en     (upd_en),
            .upd_pc     (bus.ex_pc),
            .upd_taken  (taken),
            .upd_target (target),
            .upd_jump   (is_jump)
         );
      end else begin : g_nobtb
         logic unused_upd;
         assign unused_upd  = upd_en ^ is_jump;
         assign pred_taken  = 1'b0;
         assign pred_target = pc_plus4;
      end
   endgenerate

   assign bus.pc_o          = pc_q;
   assign bus.pred_taken_o  = pred_taken;
   assign bus.pred_target_o = pred_target;
   assign bus.flush_o       = flush;
   assign bus.misalign_o    = misalign;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed test-plan scenarios plus randomized EX/trap/stall
// traffic, every cycle compared against a behavioural fetch/BTB model.
module tb_pc_gen;
   import pc_gen_pkg::*;

   localparam int          XLEN  = 32;
   localparam int          DEPTH = 16;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   pc_gen_if #(.XLEN(XLEN)) bus ();

   pc_gen #(
      .XLEN      (XLEN),
      .RESET_PC  (RPC),
      .BTB_DEPTH (DEPTH),
      .BTB_EN    (1'b1)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_pc;
   bit          m_v   [DEPTH];
   logic [31:0] m_tag [DEPTH];
   logic [31:0] m_tgt [DEPTH];
   bit          m_j   [DEPTH];
   int          m_c   [DEPTH];

   function automatic int idx(input logic [31:0] a);
      return int'((a / 4) % DEPTH);
   endfunction

   function automatic bit m_hit(input logic [31:0] a);
      return m_v[idx(a)] && (m_tag[idx(a)] == a / (4 * DEPTH));
   endfunction

   function automatic bit br_taken(input logic [3:0] br, input bit z, input bit lt);
      case (br)
         BRANCH_BEQ:               return z;
         BRANCH_BNE:               return !z;
         BRANCH_BLT, BRANCH_BLTU:  return lt;
         BRANCH_BGE, BRANCH_BGEU:  return !lt;
         BRANCH_JAL, BRANCH_JALR:  return 1'b1;
         default:                  return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] br_target(input logic [3:0] br, input logic [31:0] pc,
                                             input logic [31:0] rs1, input logic [31:0] imm);
      if (br == BRANCH_JALR) return (rs1 + imm) & 32'hFFFF_FFFE;
      return pc + imm;
   endfunction

   task automatic m_reset();
      m_pc = RPC;
      for (int k = 0; k < DEPTH; k++) m_v[k] = 1'b0;
   endtask

   task automatic idle();
      bus.stall_i = 0; bus.ex_valid = 0; bus.ex_pc = 0; bus.ex_branch = 0;
      bus.ex_zero = 0; bus.ex_lt = 0; bus.ex_rs1 = 0; bus.ex_imm = 0;
      bus.ex_pred_taken = 0; bus.ex_pred_target = 0;
      bus.trap_valid = 0; bus.trap_vec = 0;
   endtask

   task automat_ex(input logic [31:0] pc, input logic [3:0] br, input bit z,
                   input logic [31:0] imm, input bit pt, input logic [31:0] ptg);
      bus.ex_valid = 1; bus.ex_pc = pc; bus.ex_branch = br; bus.ex_zero = z;
      bus.ex_imm = imm; bus.ex_pred_taken = pt; bus.ex_pred_target = ptg;
   endtask

   // One clock: check all outputs at the negedge against the model, then
   // advance the model by the same edge the DUT sees.
   task automatic step(input string tag);
      bit tk, mis, misp, pt;
      int i, j;
      logic [31:0] tgt, act, ept, nx;
      @(negedge clk);
      i   = idx(m_pc);
      pt  = m_hit(m_pc) && (m_j[i] || m_c[i] >= 2);
      ept = pt ? m_tgt[i] : m_pc + 4;
      tk  = bus.ex_valid && br_taken(bus.ex_branch, bus.ex_zero, bus.ex_lt);
      tgt = br_target(bus.ex_branch, bus.ex_pc, bus.ex_rs1, bus.ex_imm);
      mis = tk && tgt[1];
      misp = bus.ex_valid && ((tk != bus.ex_pred_taken) || (tk && tgt != bus.ex_pred_target));
      act = tk ? tgt : bus.ex_pc + 4;
      chk({tag, ".pc"},    bus.pc_o,                 m_pc);
      chk({tag, ".pt"},    32'(bus.pred_taken_o),    32'(pt));
      chk({tag, ".ptgt"},  bus.pred_target_o,        ept);
      chk({tag, ".flush"}, 32'(bus.flush_o),         32'(bus.trap_valid || mis || misp));
      chk({tag, ".mis"},   32'(bus.misalign_o),      32'(mis));
      if      (bus.trap_valid || mis) nx = bus.trap_vec;
      else if (misp)                  nx = act;
      else if (bus.stall_i)           nx = m_pc;
      else if (pt)                    nx = ept;
      else                            nx = m_pc + 4;
      if (bus.ex_valid && bus.ex_branch != BRANCH_PCPLUS4 && !mis) begin
         j = idx(bus.ex_pc);
         if (m_hit(bus.ex_pc)) begin
            m_c[j] = tk ? ((m_c[j] == 3) ? 3 : m_c[j] + 1) : ((m_c[j] == 0) ? 0 : m_c[j] - 1);
            if (tk) m_tgt[j] = tgt;
         end else if (tk) begin
            m_v[j]   = 1'b1;
            m_tag[j] = bus.ex_pc / (4 * DEPTH);
            m_tgt[j] = tgt;
            m_j[j]   = (bus.ex_branch == BRANCH_JAL) || (bus.ex_branch == BRANCH_JALR);
            m_c[j]   = 2;
         end
      end
      m_pc = nx;
      @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic [31:0] a);
      idle(); bus.trap_valid = 1; bus.trap_vec = a;
      step("redir");
      idle();
   endtask

   logic [31:0] pcs [6] = '{32'h100, 32'h140, 32'h200, 32'h300, 32'h500, 32'h540};

   task automatic rnd();
      logic [31:0] g;
      idle();
      bus.ex_valid  = 1'($urandom_range(0, 1));
      bus.ex_pc     = pcs[$urandom_range(0, 5)];
      bus.ex_branch = 4'($urandom_range(0, 10));
      bus.ex_zero   = 1'($urandom_range(0, 1));
      bus.ex_lt     = 1'($urandom_range(0, 1));
      bus.ex_rs1    = 32'($urandom_range(0, 1023));
      bus.ex_imm    = 32'($urandom_range(0, 63)) * 4 + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd0);
      g = br_target(bus.ex_branch, bus.ex_pc, bus.ex_rs1, bus.ex_imm);
      bus.ex_pred_taken  = 1'($urandom_range(0, 1));
      bus.ex_pred_target = ($urandom_range(0, 1) == 1) ? g : pcs[$urandom_range(0, 5)];
      bus.trap_valid = ($urandom_range(0, 19) == 0);
      bus.trap_vec   = pcs[$urandom_range(0, 5)];
      bus.stall_i    = ($urandom_range(0, 3) == 0);
   endtask

   initial begin
      idle();
      m_reset();
      #12;
      chk("rst.pc",    bus.pc_o,                RPC);
      chk("rst.pt",    32'(bus.pred_taken_o),   32'd0);
      chk("rst.ptgt",  bus.pred_target_o,       RPC + 4);
      chk("rst.flush", 32'(bus.flush_o),        32'd0);
      chk("rst.mis",   32'(bus.misalign_o),     32'd0);
      @(posedge clk); #1;
      rstn = 1;

      // sequential fetch
      step("seq0"); step("seq1"); step("seq2");
      chk("seq.pc", bus.pc_o, RPC + 12);

      // BEQ 0x100 taken, predicted not-taken -> redirect to 0x140, allocate
      automat_ex(32'h100, BRANCH_BEQ, 1, 32'h40, 0, 0);
      step("beq_t");
      idle();
      chk("beq_t.pc", bus.pc_o, 32'h140);
      redirect(32'h100);
      chk("refetch.pt",   32'(bus.pred_taken_o), 32'd1);
      chk("refetch.ptgt", bus.pred_target_o,     32'h140);

      // same BEQ not taken twice while predicted taken: ctr 2->1->0
      automat_ex(32'h100, BRANCH_BEQ, 0, 32'h40, 1, 32'h140);
      step("beq_n1");
      step("beq_n2");
      redirect(32'h100);
      chk("beq_n.pt", 32'(bus.pred_taken_o), 32'd0);

      // JALR to 0x202 is misaligned: trap redirect, no BTB write
      idle();
      bus.ex_valid = 1; bus.ex_pc = 32'h180; bus.ex_branch = BRANCH_JALR;
      bus.ex_rs1 = 32'h203; bus.ex_imm = 0; bus.trap_vec = 32'h800;
      step("jalr_mis");
      idle();
      chk("jalr_mis.pc", bus.pc_o, 32'h800);
      redirect(32'h180);
      chk("jalr_mis.pt", 32'(bus.pred_taken_o), 32'd0);

      // mispredict overrides stall, then a plain stall holds
      automat_ex(32'h200, BRANCH_BEQ, 1, 32'h100, 0, 0);
      bus.stall_i = 1;
      step("stall_misp");
      chk("stall_misp.pc", bus.pc_o, 32'h300);
      idle(); bus.stall_i = 1;
      step("stall_hold");
      chk("stall_hold.pc", bus.pc_o, 32'h300);

      // trap beats a simultaneous mispredict
      automat_ex(32'h200, BRANCH_BNE, 0, 32'h100, 0, 0);
      bus.trap_valid = 1; bus.trap_vec = 32'h900;
      step("trap_misp");
      chk("trap_misp.pc", bus.pc_o, 32'h900);

      for (int n = 0; n < 400; n++) begin
         rnd();
         step("rnd");
      end

      // ensure an entry exists at 0x100, then reset mid-cycle
      idle();
      automat_ex(32'h100, BRANCH_JAL, 0, 32'h40, 0, 0);
      step("pre_rst");
      idle();
      #2 rstn = 0;
      #1;
      m_reset();
      chk("mrst.pc",    bus.pc_o,              RPC);
      chk("mrst.pt",    32'(bus.pred_taken_o), 32'd0);
      chk("mrst.flush", 32'(bus.flush_o),      32'd0);
      @(posedge clk); #1;
      rstn = 1;
      step("post_rst");
      redirect(32'h100);
      chk("mrst.pt100", 32'(bus.pred_taken_o), 32'd0);
      step("tail");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
